// File: rtl/qpsk_modulator.sv
// QPSK modulator: a 2-bit Gray-coded symbol selects the carrier phase.
// The output is a 16-sample/period 12-bit offset-binary sine.
module qpsk_modulator (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  IQ,
    output logic [11:0] sin_qpsk
);

    logic [3:0]  phase_cnt_q, phase_cnt_d;
    logic [1:0]  iq_q, iq_d;
    logic [11:0] sin_q, sin_d;
    logic [3:0]  offset;
    logic [3:0]  k;

    // Gray mapping: adjacent phases differ in one bit.
    always_comb begin
        offset = 4'd10;
        unique case (iq_q)
            2'b11: offset = 4'd2;
            2'b01: offset = 4'd6;
            2'b00: offset = 4'd10;
            2'b10: offset = 4'd14;
        endcase
    end

    always_comb begin
        phase_cnt_d = phase_cnt_q + 4'd1;
        iq_d        = IQ;
        k           = phase_cnt_q + offset;
        sin_d       = 12'd2048;
        unique case (k)
            4'd0:  sin_d = 12'd2048;
            4'd1:  sin_d = 12'd2831;
            4'd2:  sin_d = 12'd3495;
            4'd3:  sin_d = 12'd3939;
            4'd4:  sin_d = 12'd4095;
            4'd5:  sin_d = 12'd3939;
            4'd6:  sin_d = 12'd3495;
            4'd7:  sin_d = 12'd2831;
            4'd8:  sin_d = 12'd2048;
            4'd9:  sin_d = 12'd1265;
            4'd10: sin_d = 12'd601;
            4'd11: sin_d = 12'd157;
            4'd12: sin_d = 12'd1;
            4'd13: sin_d = 12'd157;
            4'd14: sin_d = 12'd601;
            4'd15: sin_d = 12'd1265;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt_q <= 4'd0;
            iq_q        <= 2'b00;
            sin_q       <= 12'd2048;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            iq_q        <= iq_d;
            sin_q       <= sin_d;
        end
    end

    assign sin_qpsk = sin_q;

endmodule

// File: tb/tb_qpsk_modulator.sv
// Directed and randomized checks for qpsk_modulator against
// hand-computed vectors and a small reference model.
module tb_qpsk_modulator;

    logic        clk;
    logic        reset;
    logic [1:0]  IQ;
    logic [11:0] sin_qpsk;

    int passed = 0;
    int total  = 0;

    logic [11:0] lut [16];
    logic [3:0]  ph;
    logic [1:0]  iqm;

    typedef struct {
        logic [1:0]  iq;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [18];

    qpsk_modulator dut (
        .clk      (clk),
        .reset    (reset),
        .IQ       (IQ),
        .sin_qpsk (sin_qpsk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] off_of(input logic [1:0] s);
        case (s)
            2'b11:   return 4'd2;
            2'b01:   return 4'd6;
            2'b00:   return 4'd10;
            default: return 4'd14;
        endcase
    endfunction

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One rising edge; e is the model's prediction for the new sample.
    task automatic tick(output logic [11:0] e);
        logic [3:0] k;
        k = ph + off_of(iqm);
        e = lut[k];
        @(posedge clk);
        ph  = ph + 4'd1;
        iqm = IQ;
        #1;
    endtask

    initial begin
        logic [11:0] e;
        logic [1:0]  syms [4];
        int mn, mx, sum;
        logic [1:0] r1, r2;

        lut = '{12'd2048, 12'd2831, 12'd3495, 12'd3939,
                12'd4095, 12'd3939, 12'd3495, 12'd2831,
                12'd2048, 12'd1265, 12'd601,  12'd157,
                12'd1,    12'd157,  12'd601,  12'd1265};
        syms = '{2'b11, 2'b01, 2'b00, 2'b10};

        tbl[0]  = '{2'b11, 12'd601};
        tbl[1]  = '{2'b11, 12'd3939};
        tbl[2]  = '{2'b11, 12'd4095};
        tbl[3]  = '{2'b11, 12'd3939};
        tbl[4]  = '{2'b11, 12'd3495};
        tbl[5]  = '{2'b11, 12'd2831};
        tbl[6]  = '{2'b11, 12'd2048};
        tbl[7]  = '{2'b11, 12'd1265};
        tbl[8]  = '{2'b11, 12'd601};
        tbl[9]  = '{2'b11, 12'd157};
        tbl[10] = '{2'b11, 12'd1};
        tbl[11] = '{2'b11, 12'd157};
        tbl[12] = '{2'b11, 12'd601};
        tbl[13] = '{2'b11, 12'd1265};
        tbl[14] = '{2'b11, 12'd2048};
        tbl[15] = '{2'b11, 12'd2831};
        tbl[16] = '{2'b11, 12'd3495};
        tbl[17] = '{2'b11, 12'd3939};

        reset = 1'b0;
        IQ    = 2'b11;
        #1 reset = 1'b1;
        #1 check("reset_value", sin_qpsk, 12'd2048);
        @(negedge clk);
        reset = 1'b0;
        ph    = 4'd0;
        iqm   = 2'b00;

        for (int i = 0; i < 18; i++) begin
            IQ = tbl[i].iq;
            tick(e);
            check($sformatf("iq11_edge%0d", i + 1), sin_qpsk, tbl[i].exp);
        end

        // 180-degree switch: new symbol shows one sample later.
        IQ = 2'b00;
        tick(e);
        check("switch_old", sin_qpsk, 12'd4095);
        tick(e);
        check("switch_new", sin_qpsk, 12'd157);

        for (int s = 0; s < 4; s++) begin
            IQ = syms[s];
            tick(e);
            tick(e);
            mn = 4096; mx = -1; sum = 0;
            for (int c = 0; c < 16; c++) begin
                tick(e);
                check($sformatf("steady_%0d_%0d", s, c), sin_qpsk, e);
                if (int'(sin_qpsk) < mn) mn = int'(sin_qpsk);
                if (int'(sin_qpsk) > mx) mx = int'(sin_qpsk);
                sum += int'(sin_qpsk);
            end
            check_int($sformatf("min_%0d", s), mn, 1);
            check_int($sformatf("max_%0d", s), mx, 4095);
            check_int($sformatf("mean_%0d", s), sum / 16, 2048);
        end

        // IQ toggles each half period; only the value at the edge counts.
        for (int c = 0; c < 120; c++) begin
            r1 = 2'($urandom_range(0, 3));
            r2 = 2'($urandom_range(0, 3));
            IQ = r1;
            @(negedge clk);
            IQ = r2;
            tick(e);
            total++;
            if (!$isunknown(sin_qpsk)) passed++;
            else $display("FAIL rand_x_%0d: got %h, expected known", c, sin_qpsk);
            check($sformatf("rand_%0d", c), sin_qpsk, e);
        end

        #1 reset = 1'b1;
        #1 check("midstream_reset", sin_qpsk, 12'd2048);
        @(negedge clk);
        reset = 1'b0;
        ph    = 4'd0;
        iqm   = 2'b00;
        IQ    = 2'b01;
        tick(e);
        check("post_reset_edge1", sin_qpsk, 12'd601);
        tick(e);
        check("post_reset_edge2", sin_qpsk, 12'd2831);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
